seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier.sv | 164 ++++++++++++++++
 tb/tb_seq_multiplier.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
//   Shift-and-add sequential multiplier. One multiplier bit is consumed per
//   clock, LSB first, so a multiply always takes DW cycles in RUN. It then
//   spends one cycle in DONE, where the registered product is published with a
//   single-cycle ready pulse.
//
//   Optional feature: define MULT_SIGNED_EN to treat the operands as two's
//   complement. The operand magnitudes are multiplied and the result is
//   negated on entry to DONE when the operand signs differ. Latency does not
//   change. Without the macro the block is purely unsigned.
//
// Parameters
//   DW            operand width in bits (product is 2*DW bits)
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   start         begin a multiply (sampled only in IDLE)
//   multiplicand  operand A, captured on the edge that accepts start
//   multiplier    operand B, captured on the edge that accepts start
//   product       registered result, held until the next accepted start
//   ready         one-cycle pulse while product is fresh (DONE state)
//   busy          high in RUN and DONE
// -----------------------------------------------------------------------------
module seq_multiplier #(
    parameter int DW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DW-1:0]     multiplicand,
    input  logic [DW-1:0]     multiplier,
    output logic [2*DW-1:0]   product,
    output logic              ready,
    output logic              busy
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*DW-1:0]   mcand_q, mcand_d;    // shifts left, so needs 2*DW bits
    logic [DW-1:0]     mplier_q, mplier_d;  // shifts right, bit 0 is current bit
    logic [2*DW-1:0]   acc_q, acc_d;
    logic [2*DW-1:0]   product_q, product_d;
    logic              ready_q, ready_d;

    logic              last_bit;
    logic [2*DW-1:0]   acc_sum;
    logic [2*DW-1:0]   result;
    logic [DW-1:0]     a_mag;
    logic [DW-1:0]     b_mag;

`ifdef MULT_SIGNED_EN
    logic              neg_q, neg_d;

    // Magnitudes of the most negative value wrap to themselves, which is the
    // correct unsigned magnitude at DW bits.
    assign a_mag  = multiplicand[DW-1] ? (~multiplicand + 1'b1) : multiplicand;
    assign b_mag  = multiplier[DW-1]   ? (~multiplier + 1'b1)   : multiplier;
    assign result = neg_q ? (~acc_sum + 1'b1) : acc_sum;
`else
    assign a_mag  = multiplicand;
    assign b_mag  = multiplier;
    assign result = acc_sum;
`endif

    assign last_bit = (cnt_q == CW'(DW - 1));
    // The final RUN cycle's partial product must be included in the result,
    // so DONE is loaded from the sum rather than from acc_q.
    assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

    // ---------------------------------------------------------------- state reg
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            product_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            ready_q   <= ready_d;
        end
    end

`ifdef MULT_SIGNED_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) neg_q <= 1'b0;
        else     neg_q <= neg_d;
    end
`endif

    // --------------------------------------------------------------- next state
    // NOTE: every combinational output gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ----------------------------------------------------------------- datapath
    always_comb begin
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        product_d = product_q;
`ifdef MULT_SIGNED_EN
        neg_d     = neg_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = {{DW{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    acc_d    = '0;
                    cnt_d    = '0;
`ifdef MULT_SIGNED_EN
                    neg_d    = multiplicand[DW-1] ^ multiplier[DW-1];
`endif
                end
            end
            RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (last_bit) product_d = result;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------ outputs
    always_comb begin
        ready_d = (state_q == RUN) && last_bit;
        busy    = (state_q != IDLE);
        ready   = ready_q;
        product = product_q;
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// -----------------------------------------------------------------------------
// tb_seq_multiplier
//   Directed bench for seq_multiplier (DW=16). Expected products are
//   hand-computed; the MULT_SIGNED_EN build selects the signed expectations.
//   Cycle numbering: the edge that accepts start ends cycle 0, so the block
//   is in RUN during cycle 1 and ready is expected in cycle 17 only.
// -----------------------------------------------------------------------------
module tb_seq_multiplier;

    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [DW-1:0]   multiplicand;
    logic [DW-1:0]   multiplier;
    logic [2*DW-1:0] product;
    logic            ready;
    logic            busy;

    int n_checks = 0;
    int n_fails  = 0;

    seq_multiplier #(.DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .ready        (ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch one multiply and follow it through cycle 18. Operands are
    // scrambled after capture, and if glitch_cyc is non-zero a start with
    // A=B=2 is pulsed in that cycle; neither may disturb the result.
    task automatic run_mult(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [2*DW-1:0] exp, input logic [2*DW-1:0] prev,
                            input int glitch_cyc);
        int first_rdy = -1;
        int n_rdy     = 0;
        int busy_bad  = 0;
        int hold_bad  = 0;
        @(negedge clk);
        start = 1'b1; multiplicand = a; multiplier = b;
        @(posedge clk); #1;
        for (int c = 1; c <= 18; c++) begin
            if (c == glitch_cyc) begin
                start = 1'b1; multiplicand = 16'd2; multiplier = 16'd2;
            end else begin
                start = 1'b0; multiplicand = DW'($urandom); multiplier = DW'($urandom);
            end
            if (ready) begin
                n_rdy++;
                if (first_rdy < 0) first_rdy = c;
            end
            if (busy !== (c <= 17)) busy_bad++;
            if (c < 17 && product !== prev) hold_bad++;
            if (c == 17) check({tag, "_product"}, 64'(product), 64'(exp));
            @(posedge clk); #1;
        end
        start = 1'b0;
        check({tag, "_ready_cycle"}, 64'(first_rdy), 64'd17);
        check({tag, "_ready_count"}, 64'(n_rdy), 64'd1);
        check({tag, "_busy_window"}, 64'(busy_bad), 64'd0);
        check({tag, "_product_held"}, 64'(hold_bad), 64'd0);
        // Now in cycle 19 relative to the start: block idle, result still held.
        check({tag, "_product_after"}, 64'(product), 64'(exp));
    endtask

    initial begin
        int n_rdy;
        rst = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
        #1;
        check("rst_async_product", 64'(product), 64'd0);
        check("rst_async_ready",   64'(ready),   64'd0);
        check("rst_async_busy",    64'(busy),    64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;

        run_mult("a3_b5", 16'd3, 16'd5, 32'h0000_000F, 32'h0, 0);
`ifdef MULT_SIGNED_EN
        run_mult("ffff_ffff", 16'hFFFF, 16'hFFFF, 32'h0000_0001, 32'h0000_000F, 0);
        run_mult("fffd_5",    16'hFFFD, 16'd5,    32'hFFFF_FFF1, 32'h0000_0001, 0);
        run_mult("8000_8000", 16'h8000, 16'h8000, 32'h4000_0000, 32'hFFFF_FFF1, 0);
`else
        run_mult("ffff_ffff", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 32'h0000_000F, 0);
        run_mult("fffd_5",    16'hFFFD, 16'd5,    32'h0004_FFF1, 32'hFFFE_0001, 0);
        run_mult("8000_8000", 16'h8000, 16'h8000, 32'h4000_0000, 32'h0004_FFF1, 0);
`endif
        // Start pulsed mid-RUN with other operands must be ignored.
        run_mult("ignore_start", 16'd7, 16'd9, 32'd63, 32'h4000_0000, 5);

        // Reset in cycle 8 of a multiply, after an ignored start in cycle 5.
        @(negedge clk);
        start = 1'b1; multiplicand = 16'd7; multiplier = 16'd9;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 8; c++) begin
            start = (c == 5);
            if (c == 5) begin multiplicand = 16'd2; multiplier = 16'd2; end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("pre_rst_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_busy",    64'(busy),    64'd0);
        check("mid_rst_product", 64'(product), 64'd0);
        check("mid_rst_ready",   64'(ready),   64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        n_rdy = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (ready || busy) n_rdy++;
        end
        check("post_rst_no_activity", 64'(n_rdy), 64'd0);
        run_mult("after_rst", 16'd2, 16'd2, 32'd4, 32'd0, 0);

        // Back-to-back: the second start lands in the IDLE cycle right after
        // DONE (cycle 18 of the first), so its ready is 18 cycles later.
        run_mult("b2b_first", 16'h0000, 16'h1234, 32'h0, 32'd4, 0);
        start = 1'b0;
        n_rdy = 0;
        begin : b2b_gap
            // run_mult returns one cycle late for an immediate restart, so
            // repeat the first multiply and follow it cycle by cycle here.
            int rdy1 = -1;
            int rdy2 = -1;
            int held_bad = 0;
            @(negedge clk);
            start = 1'b1; multiplicand = 16'h0000; multiplier = 16'h1234;
            for (int c = 1; c <= 40; c++) begin
                @(posedge clk); #1;
                start = 1'b0;
                if (ready && rdy1 < 0) begin
                    rdy1 = c;
                    check("b2b_first_product", 64'(product), 64'h0);
                end else if (ready && rdy2 < 0) begin
                    rdy2 = c;
                    check("b2b_second_product", 64'(product), 64'h0001_0000);
                end
                if (rdy1 > 0 && rdy2 < 0 && !ready && product !== 32'h0) held_bad++;
                if (c == 18) begin
                    // cycle 18 is the IDLE cycle after DONE: start here
                    start = 1'b1; multiplicand = 16'h0100; multiplier = 16'h0100;
                end
            end
            start = 1'b0;
            check("b2b_gap", 64'(rdy2 - rdy1), 64'd18);
            check("b2b_first_held", 64'(held_bad), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
